// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Holds the FSM state encoding, the write source encoding and the default starvation limit.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAST_ALU = 2'd1,
    LAST_MEM = 2'd2
  } wb_state_e;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

  localparam int unsigned STARVE_MAX_DEFAULT = 3;

  // Four-bit counter increment that sticks at 15 instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] value);
    return (value == 4'hF) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back bus: two result producers (ALU, MEM) and the register-file write port.
// master = producers/register file side, slave = the arbiter.
interface wb_arbiter_if;

  logic       alu_valid;
  logic [7:0] alu_data;
  logic [2:0] alu_rd;
  logic       alu_ready;

  logic       mem_valid;
  logic [7:0] mem_data;
  logic [2:0] mem_rd;
  logic       mem_ready;

  logic       rf_stall;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       wb_sel;

  modport master (
    output alu_valid, alu_data, alu_rd, mem_valid, mem_data, mem_rd, rf_stall,
    input  alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, wb_sel
  );

  modport slave (
    input  alu_valid, alu_data, alu_rd, mem_valid, mem_data, mem_rd, rf_stall,
    output alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, wb_sel
  );

endinterface

// File: rtl/MUX_2x1.sv
// Team two-input multiplexer, 8 bits wide by default; sel=1 picks input b.
module MUX_2x1 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates ALU and MEM results onto one register-file write port.
// MEM wins contention until it has starved the ALU for STARVE_MAX consecutive grants.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_LAST_ALU = LAST_ALU;
  localparam logic [1:0] S_LAST_MEM = LAST_MEM;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0] state;
  logic [1:0] state_next;
  logic [3:0] streak;
  logic [3:0] streak_next;
  logic       grant_alu;
  logic       grant_mem;
  logic       starved;

  logic [7:0] sel_data;
  logic [2:0] sel_rd;
  logic [7:0] wdata_q;
  logic [2:0] waddr_q;
  wb_src_e    wb_sel_q;

  assign starved = (streak == STARVE_LIM);

  // Grants look only at valids, stall, reset and the streak, never at data or rd.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!rst && !bus.rf_stall) begin
      if (bus.alu_valid && (!bus.mem_valid || starved)) begin
        grant_alu = 1'b1;
      end else if (bus.mem_valid) begin
        grant_mem = 1'b1;
      end
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;

  MUX_2x1 #(.WIDTH(8)) u_data_mux (
    .a   (bus.alu_data),
    .b   (bus.mem_data),
    .sel (grant_mem),
    .y   (sel_data)
  );

  MUX_2x1 #(.WIDTH(3)) u_addr_mux (
    .a   (bus.alu_rd),
    .b   (bus.mem_rd),
    .sel (grant_mem),
    .y   (sel_rd)
  );

  always_comb begin
    state_next  = S_IDLE;
    streak_next = streak;
    if (grant_alu) begin
      state_next  = S_LAST_ALU;
      streak_next = '0;
    end else if (grant_mem) begin
      state_next  = S_LAST_MEM;
      // The streak only measures MEM wins that actually made the ALU wait.
      streak_next = bus.alu_valid ? sat_inc(streak) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      streak   <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wb_sel_q <= SRC_ALU;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state  <= state_next;
      streak <= streak_next;
      if (grant_alu || grant_mem) begin
        waddr_q  <= sel_rd;
        wdata_q  <= sel_data;
        wb_sel_q <= grant_mem ? SRC_MEM : SRC_ALU;
      end
    end
  end

  // A write happened last cycle exactly when the FSM left IDLE.
  assign bus.rf_we    = (state != S_IDLE);
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;
  assign bus.wb_sel   = wb_sel_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scenarios plus randomized traffic against a rule-level model of the arbiter.
module tb_wb_arbiter;

  localparam int SM     = 3;
  localparam int G_NONE = 0;
  localparam int G_ALU  = 1;
  localparam int G_MEM  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter #(.STARVE_MAX(SM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: consecutive MEM wins over a waiting ALU, plus the expected write port.
  int         m_streak;
  logic       m_we;
  logic [2:0] m_waddr;
  logic [7:0] m_wdata;
  logic       m_sel;
  int         last_grant;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_streak = 0;
    m_we     = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
    m_sel    = 1'b0;
  endtask

  function automatic int model_grant();
    if (rst || bus.rf_stall) return G_NONE;
    if (bus.alu_valid && bus.mem_valid) return (m_streak == SM) ? G_ALU : G_MEM;
    if (bus.alu_valid) return G_ALU;
    if (bus.mem_valid) return G_MEM;
    return G_NONE;
  endfunction

  task automatic check_rf(input string tag);
    check({tag, ".rf_we"},    8'(bus.rf_we),    8'(m_we));
    check({tag, ".rf_waddr"}, 8'(bus.rf_waddr), 8'(m_waddr));
    check({tag, ".rf_wdata"}, bus.rf_wdata,     m_wdata);
    check({tag, ".wb_sel"},   8'(bus.wb_sel),   8'(m_sel));
  endtask

  // One clock: check readies, take the edge, update the model, check the write port.
  task automatic cycle(input string tag);
    int         g;
    logic       a_v;
    logic [7:0] a_d, m_d;
    logic [2:0] a_r, m_r;
    #1;
    g   = model_grant();
    a_v = bus.alu_valid;
    a_d = bus.alu_data;
    a_r = bus.alu_rd;
    m_d = bus.mem_data;
    m_r = bus.mem_rd;
    check({tag, ".alu_ready"}, 8'(bus.alu_ready), 8'(g == G_ALU));
    check({tag, ".mem_ready"}, 8'(bus.mem_ready), 8'(g == G_MEM));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (g == G_ALU) begin
      m_we = 1'b1; m_waddr = a_r; m_wdata = a_d; m_sel = 1'b0;
      m_streak = 0;
    end else if (g == G_MEM) begin
      m_we = 1'b1; m_waddr = m_r; m_wdata = m_d; m_sel = 1'b1;
      m_streak = a_v ? ((m_streak < 15) ? m_streak + 1 : 15) : 0;
    end else begin
      m_we = 1'b0;
    end
    last_grant = g;
    #1;
    check_rf(tag);
  endtask

  // Reset pulse placed between clock edges; outputs must clear before any edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_rf(tag);
    check({tag, ".alu_ready"}, 8'(bus.alu_ready), 8'h00);
    check({tag, ".mem_ready"}, 8'(bus.mem_ready), 8'h00);
    #1 rst = 1'b0;
  endtask

  task automatic set_alu(input logic v, input logic [7:0] d, input logic [2:0] r);
    bus.alu_valid = v; bus.alu_data = d; bus.alu_rd = r;
  endtask

  task automatic set_mem(input logic v, input logic [7:0] d, input logic [2:0] r);
    bus.mem_valid = v; bus.mem_data = d; bus.mem_rd = r;
  endtask

  initial begin
    rst = 1'b1;
    set_alu(1'b0, 8'h00, 3'd0);
    set_mem(1'b0, 8'h00, 3'd0);
    bus.rf_stall = 1'b0;
    model_reset();
    last_grant = G_NONE;
    #1;
    check_rf("reset");

    // Held in reset with a pending ALU result: nothing granted until release.
    set_alu(1'b1, 8'h77, 3'd1);
    cycle("in_reset0");
    cycle("in_reset1");
    rst = 1'b0;
    cycle("first_edge");
    check("first_edge.we", 8'(bus.rf_we), 8'h01);
    bus.alu_valid = 1'b0;

    // Single ALU write, then an idle cycle that must hold the write port.
    set_alu(1'b1, 8'h5A, 3'd3);
    cycle("single");
    check("single.waddr", 8'(bus.rf_waddr), 8'h03);
    check("single.wdata", bus.rf_wdata, 8'h5A);
    check("single.sel", 8'(bus.wb_sel), 8'h00);
    bus.alu_valid = 1'b0;
    cycle("single_idle");

    // Continuous contention: MEM, MEM, MEM, ALU repeating.
    async_reset("rst_contend");
    set_alu(1'b1, 8'hA1, 3'd2);
    set_mem(1'b1, 8'hB2, 3'd4);
    for (int i = 0; i < 12; i++) begin
      cycle("contend");
      check("contend.order", 8'(bus.wb_sel), 8'((i % 4) != 3));
    end

    // Stall after two MEM wins: resume with the third MEM, then ALU.
    async_reset("rst_stall");
    cycle("pre_stall0");
    cycle("pre_stall1");
    bus.rf_stall = 1'b1;
    cycle("stall0");
    check("stall0.we", 8'(bus.rf_we), 8'h00);
    cycle("stall1");
    check("stall1.we", 8'(bus.rf_we), 8'h00);
    bus.rf_stall = 1'b0;
    cycle("resume0");
    check("resume0.sel", 8'(bus.wb_sel), 8'h01);
    cycle("resume1");
    check("resume1.sel", 8'(bus.wb_sel), 8'h00);

    // Reset mid-stream after two MEM wins: streak restarts, MEM wins first.
    async_reset("rst_mid_a");
    cycle("mid0");
    cycle("mid1");
    async_reset("rst_mid_b");
    cycle("post_rst0");
    check("post_rst0.sel", 8'(bus.wb_sel), 8'h01);
    for (int i = 1; i < 5; i++) cycle("post_rst");

    // Same destination on both sides: two separate writes, MEM first.
    async_reset("rst_same_rd");
    set_alu(1'b1, 8'h11, 3'd5);
    set_mem(1'b1, 8'h22, 3'd5);
    cycle("same_rd0");
    check("same_rd0.wdata", bus.rf_wdata, 8'h22);
    bus.mem_valid = 1'b0;
    cycle("same_rd1");
    check("same_rd1.wdata", bus.rf_wdata, 8'h11);
    check("same_rd1.waddr", 8'(bus.rf_waddr), 8'h05);
    bus.alu_valid = 1'b0;
    cycle("same_rd_idle");

    // Random traffic: requests stay stable until transferred.
    async_reset("rst_random");
    for (int n = 0; n < 400; n++) begin
      if (!bus.alu_valid)
        set_alu(($urandom % 10) < 6, 8'($urandom), 3'($urandom));
      if (!bus.mem_valid)
        set_mem(($urandom % 10) < 6, 8'($urandom), 3'($urandom));
      bus.rf_stall = (($urandom % 5) == 0);
      cycle("random");
      if (last_grant == G_ALU) bus.alu_valid = 1'b0;
      if (last_grant == G_MEM) bus.mem_valid = 1'b0;
      if (($urandom % 60) == 0) async_reset("random_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
